// File: rtl/sq_drain_ctrl_if.sv
// Store-queue port bundle: LSU push, ROB commit/flush, dcache write request/ack, status.
interface sq_drain_ctrl_if #(
  parameter int NR_SQ_ENTRIES = 8,
  parameter int XLEN          = 64,
  parameter int ID_W          = 8,
  parameter int SQID_W        = $clog2(NR_SQ_ENTRIES)
);
  logic              push_valid;
  logic              push_ready;
  logic [ID_W-1:0]   push_id;
  logic [XLEN-1:0]   push_paddr;
  logic [1:0]        push_size;
  logic [XLEN-1:0]   push_data;
  logic [SQID_W-1:0] push_sqid;
  logic              commit_valid;
  logic              flush;
  logic              dc_req_valid;
  logic              dc_req_ready;
  logic [XLEN-1:0]   dc_req_paddr;
  logic [XLEN-1:0]   dc_req_data;
  logic [7:0]        dc_req_be;
  logic              dc_rsp_valid;
  logic [SQID_W:0]   sq_count;
  logic              sq_empty;

  modport master (
    output push_valid, push_id, push_paddr, push_size, push_data,
           commit_valid, flush, dc_req_ready, dc_rsp_valid,
    input  push_ready, push_sqid, dc_req_valid, dc_req_paddr, dc_req_data,
           dc_req_be, sq_count, sq_empty
  );

  modport slave (
    input  push_valid, push_id, push_paddr, push_size, push_data,
           commit_valid, flush, dc_req_ready, dc_rsp_valid,
    output push_ready, push_sqid, dc_req_valid, dc_req_paddr, dc_req_data,
           dc_req_be, sq_count, sq_empty
  );
endinterface

// File: rtl/sq_drain_ctrl.sv
// Store queue: allocates resolved stores, commits in order, drains committed
// entries one at a time to the dcache write port; flush drops uncommitted ones.
module sq_drain_ctrl #(
  parameter int NR_SQ_ENTRIES = 8,
  parameter int XLEN          = 64,
  parameter int ID_W          = 8,
  parameter int SQID_W        = $clog2(NR_SQ_ENTRIES)
) (
  input logic           clk,
  input logic           rst,
  sq_drain_ctrl_if.slave bus
);
  typedef logic [SQID_W:0] ptr_t;

  typedef struct packed {
    logic [XLEN-1:0] paddr;
    logic [1:0]      size;
    logic [XLEN-1:0] data;
  } sq_entry_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  sq_entry_t       mem [NR_SQ_ENTRIES];
  ptr_t            alloc_ptr, commit_ptr, head_ptr, count, commit_nxt;
  state_t          state, state_nxt;
  logic            full, push_fire, load_req, head_adv;
  sq_entry_t       head_ent;
  logic [2:0]      off;
  logic [7:0]      be_nxt;
  logic [XLEN-1:0] data_nxt;
  logic [XLEN-1:0] req_paddr, req_data;
  logic [7:0]      req_be;
  logic            unused_ok;

  // Pointers carry a wrap bit, so full vs empty is just the MSB of the difference.
  assign count          = alloc_ptr - head_ptr;
  assign full           = (count == ptr_t'(NR_SQ_ENTRIES));
  assign bus.push_ready = !full && !bus.flush;
  assign push_fire      = bus.push_valid && bus.push_ready;
  assign bus.push_sqid  = alloc_ptr[SQID_W-1:0];
  assign commit_nxt     = commit_ptr + ptr_t'(bus.commit_valid);
  assign bus.sq_count   = count;
  assign bus.sq_empty   = (count == '0);
  assign unused_ok      = ^bus.push_id;

  assign head_ent = mem[head_ptr[SQID_W-1:0]];
  assign off      = head_ent.paddr[2:0];

  always_comb begin
    be_nxt   = 8'h00;
    data_nxt = head_ent.data << {off, 3'b000};
    case (head_ent.size)
      2'd0:    be_nxt = 8'h01 << off;
      2'd1:    be_nxt = 8'h03 << off;
      2'd2:    be_nxt = 8'h0F << off;
      default: be_nxt = 8'hFF;
    endcase
  end

  always_comb begin
    state_nxt = state;
    load_req  = 1'b0;
    head_adv  = 1'b0;
    case (state)
      IDLE: if (head_ptr != commit_ptr) begin
        state_nxt = REQ;
        load_req  = 1'b1;
      end
      REQ:  if (bus.dc_req_ready) state_nxt = WAIT;
      WAIT: if (bus.dc_rsp_valid) begin
        state_nxt = IDLE;
        head_adv  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.dc_req_valid = (state == REQ);
  assign bus.dc_req_paddr = req_paddr;
  assign bus.dc_req_data  = req_data;
  assign bus.dc_req_be    = req_be;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alloc_ptr  <= '0;
      commit_ptr <= '0;
      head_ptr   <= '0;
      req_paddr  <= '0;
      req_data   <= '0;
      req_be     <= '0;
    end else begin
      state      <= state_nxt;
      commit_ptr <= commit_nxt;
      // Flush rewinds allocation onto the (post-commit) pointer; a same-cycle push never fired.
      alloc_ptr  <= bus.flush ? commit_nxt : alloc_ptr + ptr_t'(push_fire);
      if (head_adv) head_ptr <= head_ptr + ptr_t'(1);
      if (load_req) begin
        req_paddr <= {head_ent.paddr[XLEN-1:3], 3'b000};
        req_data  <= data_nxt;
        req_be    <= be_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire)
      mem[alloc_ptr[SQID_W-1:0]] <= '{paddr: bus.push_paddr, size: bus.push_size, data: bus.push_data};
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.commit_valid && commit_ptr == alloc_ptr))
        else $error("sq_drain_ctrl: commit with no uncommitted store");
      assert (!(bus.dc_rsp_valid && state != WAIT))
        else $error("sq_drain_ctrl: dcache ack with no outstanding request");
    end
  end
`endif
endmodule

// File: tb/tb_sq_drain_ctrl.sv
// Directed bench for sq_drain_ctrl: single store, fill, flush, backpressure, wrap, simultaneous ops.
module tb_sq_drain_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sq_drain_ctrl_if #(.NR_SQ_ENTRIES(8), .XLEN(64), .ID_W(8), .SQID_W(3)) bus ();

  sq_drain_ctrl #(.NR_SQ_ENTRIES(8), .XLEN(64), .ID_W(8), .SQID_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] pa, input logic [1:0] sz, input logic [63:0] d,
                      input logic [2:0] esq, input string tag);
    bus.push_valid = 1'b1;
    bus.push_paddr = pa;
    bus.push_size  = sz;
    bus.push_data  = d;
    bus.push_id    = bus.push_id + 8'd1;
    #1;
    chk({tag, "_rdy"},  64'(bus.push_ready), 64'd1);
    chk({tag, "_sqid"}, 64'(bus.push_sqid),  64'(esq));
    cyc();
    bus.push_valid = 1'b0;
  endtask

  task automatic commit();
    bus.commit_valid = 1'b1;
    cyc();
    bus.commit_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  // Waits (bounded) for a request, checks its fields, accepts it; returns in WAIT.
  task automatic drain_req(input logic [63:0] ep, input logic [63:0] ed, input logic [7:0] ebe,
                           input string tag);
    int n = 0;
    while (!bus.dc_req_valid && n < 20) begin
      cyc();
      n++;
    end
    chk({tag, "_vld"}, 64'(bus.dc_req_valid), 64'd1);
    chk({tag, "_pa"},  bus.dc_req_paddr, ep);
    chk({tag, "_dat"}, bus.dc_req_data,  ed);
    chk({tag, "_be"},  64'(bus.dc_req_be), 64'(ebe));
    bus.dc_req_ready = 1'b1;
    cyc();
    bus.dc_req_ready = 1'b0;
    chk({tag, "_vld_wait"}, 64'(bus.dc_req_valid), 64'd0);
  endtask

  task automatic drain_one(input logic [63:0] ep, input logic [63:0] ed, input logic [7:0] ebe,
                           input string tag);
    drain_req(ep, ed, ebe, tag);
    bus.dc_rsp_valid = 1'b1;
    cyc();
    bus.dc_rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.push_valid   = 1'b0;
    bus.push_id      = '0;
    bus.push_paddr   = '0;
    bus.push_size    = '0;
    bus.push_data    = '0;
    bus.commit_valid = 1'b0;
    bus.flush        = 1'b0;
    bus.dc_req_ready = 1'b0;
    bus.dc_rsp_valid = 1'b0;
    do_reset();

    // reset state
    chk("rst_rdy",   64'(bus.push_ready),   64'd1);
    chk("rst_cnt",   64'(bus.sq_count),     64'd0);
    chk("rst_empty", 64'(bus.sq_empty),     64'd1);
    chk("rst_vld",   64'(bus.dc_req_valid), 64'd0);
    chk("rst_pa",    bus.dc_req_paddr,      64'd0);
    chk("rst_dat",   bus.dc_req_data,       64'd0);
    chk("rst_be",    64'(bus.dc_req_be),    64'd0);

    // single byte store, exact commit-to-request latency
    push(64'h1003, 2'd0, 64'hAB, 3'd0, "single_push");
    commit();
    chk("single_vld_t1", 64'(bus.dc_req_valid), 64'd0);
    cyc();
    drain_one(64'h1000, 64'hAB00_0000, 8'h08, "single");
    chk("single_cnt",   64'(bus.sq_count), 64'd0);
    chk("single_empty", 64'(bus.sq_empty), 64'd1);

    // fill to depth with no commits (pointers start at 1)
    for (int i = 0; i < 8; i++)
      push(64'h2000 + 64'(8 * i), 2'd3, 64'(i), 3'(i + 1), "fill_push");
    chk("fill_rdy", 64'(bus.push_ready), 64'd0);
    chk("fill_cnt", 64'(bus.sq_count),   64'd8);
    commit();
    drain_req(64'h2000, 64'd0, 8'hFF, "fill_drain");
    chk("fill_rdy_wait", 64'(bus.push_ready), 64'd0);
    bus.dc_rsp_valid = 1'b1;
    cyc();
    bus.dc_rsp_valid = 1'b0;
    chk("fill_rdy_ack", 64'(bus.push_ready), 64'd1);
    chk("fill_cnt_ack", 64'(bus.sq_count),   64'd7);
    bus.flush = 1'b1;
    #1;
    chk("fill_rdy_flush", 64'(bus.push_ready), 64'd0);
    cyc();
    bus.flush = 1'b0;
    chk("fill_cnt_flush", 64'(bus.sq_count), 64'd0);

    // flush keeps only committed stores
    do_reset();
    for (int i = 0; i < 4; i++)
      push(64'h3000 + 64'(8 * i), 2'd3, 64'h30 + 64'(i), 3'(i), "fl_push");
    commit();
    commit();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("fl_cnt", 64'(bus.sq_count), 64'd2);
    drain_one(64'h3000, 64'h30, 8'hFF, "fl_d0");
    drain_one(64'h3008, 64'h31, 8'hFF, "fl_d1");
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("fl_no_third", 64'(bus.dc_req_valid), 64'd0);
    end
    chk("fl_empty", 64'(bus.sq_empty), 64'd1);
    push(64'h3100, 2'd3, 64'h99, 3'd2, "fl_next");

    // backpressure then late ack
    do_reset();
    push(64'h4006, 2'd1, 64'hBEEF, 3'd0, "bp_push");
    commit();
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", 64'(bus.dc_req_valid), 64'd1);
      chk("bp_pa",  bus.dc_req_paddr,      64'h4000);
      chk("bp_dat", bus.dc_req_data,       64'hBEEF_0000_0000_0000);
      chk("bp_be",  64'(bus.dc_req_be),    64'hC0);
      cyc();
    end
    drain_req(64'h4000, 64'hBEEF_0000_0000_0000, 8'hC0, "bp_acc");
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_wait_vld", 64'(bus.dc_req_valid), 64'd0);
      chk("bp_wait_cnt", 64'(bus.sq_count),     64'd1);
    end
    bus.dc_rsp_valid = 1'b1;
    cyc();
    bus.dc_rsp_valid = 1'b0;
    chk("bp_cnt",   64'(bus.sq_count), 64'd0);
    chk("bp_empty", 64'(bus.sq_empty), 64'd1);

    // wrap through the queue 2.5 times with word stores in both lanes
    do_reset();
    for (int i = 0; i < 20; i++) begin
      logic [63:0] pa, d, ed;
      logic [7:0]  ebe;
      pa  = 64'h5000 + 64'(8 * i) + ((i % 2 == 1) ? 64'd4 : 64'd0);
      d   = 64'h100 + 64'(i);
      ed  = (i % 2 == 1) ? (d << 32) : d;
      ebe = (i % 2 == 1) ? 8'hF0 : 8'h0F;
      push(pa, 2'd2, d, 3'(i), "wrap_push");
      commit();
      drain_one(pa & ~64'h7, ed, ebe, "wrap");
      chk("wrap_cnt",   64'(bus.sq_count),   64'd0);
      chk("wrap_empty", 64'(bus.sq_empty),   64'd1);
      chk("wrap_rdy",   64'(bus.push_ready), 64'd1);
    end

    // push + commit + ack in one cycle, then reset mid-REQ
    do_reset();
    push(64'h6000, 2'd3, 64'hA0, 3'd0, "sim_pa");
    push(64'h6008, 2'd3, 64'hB0, 3'd1, "sim_pb");
    push(64'h6010, 2'd3, 64'hC0, 3'd2, "sim_pc");
    commit();
    drain_req(64'h6000, 64'hA0, 8'hFF, "sim_a");
    chk("sim_cnt_pre", 64'(bus.sq_count), 64'd3);
    bus.push_valid   = 1'b1;
    bus.push_paddr   = 64'h6018;
    bus.push_size    = 2'd3;
    bus.push_data    = 64'hD0;
    bus.commit_valid = 1'b1;
    bus.dc_rsp_valid = 1'b1;
    cyc();
    bus.push_valid   = 1'b0;
    bus.commit_valid = 1'b0;
    bus.dc_rsp_valid = 1'b0;
    chk("sim_cnt", 64'(bus.sq_count), 64'd3);
    drain_one(64'h6008, 64'hB0, 8'hFF, "sim_b");
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("sim_no_c", 64'(bus.dc_req_valid), 64'd0);
    end
    chk("sim_cnt_cd", 64'(bus.sq_count), 64'd2);
    commit();
    cyc();
    chk("sim_c_vld", 64'(bus.dc_req_valid), 64'd1);
    chk("sim_c_pa",  bus.dc_req_paddr,      64'h6010);
    rst = 1'b1;
    cyc();
    chk("sim_rst_vld",   64'(bus.dc_req_valid), 64'd0);
    chk("sim_rst_cnt",   64'(bus.sq_count),     64'd0);
    chk("sim_rst_empty", 64'(bus.sq_empty),     64'd1);
    chk("sim_rst_pa",    bus.dc_req_paddr,      64'd0);
    rst = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sq_drain_ctrl.md
Name: sq_drain_ctrl

Overview:
Store-queue sequencer between the LSU address stage, the ROB commit stream and the data-cache write port. It owns SQ storage and its alloc/commit/drain pointers. It accepts resolved stores, marks them committed in program order, and drains committed stores one at a time to the dcache over a valid/ready request and ack protocol. Uncommitted stores are discarded on a pipeline flush.

Parameters:
NR_SQ_ENTRIES, 8, SQ depth; power of two, at least 2
XLEN, 64, address/data width
ID_W, 8, instruction id width
SQID_W, $clog2(NR_SQ_ENTRIES), SQ index width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
push_valid_i  in  1  resolved store offered by LSU
push_ready_o  out  1  free entry available
push_id_i  in  ID_W  instruction id
push_paddr_i  in  XLEN  physical address
push_size_i  in  2  0=B,1=H,2=W,3=D
push_data_i  in  XLEN  store data, LSB-aligned
push_sqid_o  out  SQID_W  index allocated to this push (valid with handshake)
commit_valid_i  in  1  ROB commits oldest uncommitted store
flush_i  in  1  discard all uncommitted entries
dc_req_valid_o  out  1  dcache write request
dc_req_ready_i  in  1  dcache accepts request
dc_req_paddr_o  out  XLEN  address, bits[2:0] forced to 0
dc_req_data_o  out  XLEN  data shifted to byte lane
dc_req_be_o  out  8  byte enables
dc_rsp_valid_i  in  1  write ack, one per accepted request
sq_count_o  out  SQID_W+1  occupied entries
sq_empty_o  out  1  no entries (fence/drain done)

Behaviour:
- Pointers alloc/commit/head are SQID_W+1 bits, with the MSB as wrap bit. Invariant: head <= commit <= alloc in modulo order. count = alloc - head. Full when count == NR_SQ_ENTRIES.
- Reset values: all pointers 0, FSM IDLE, dc_req_valid_o=0, push_ready_o=1, sq_count_o=0, sq_empty_o=1. dc_req_* data outputs are 0.
- push_ready_o = !full, combinational from registered state. On push_valid_i&&push_ready_o the entry at alloc is written at the clock edge and alloc advances. push_sqid_o = alloc[SQID_W-1:0].
- On commit_valid_i, commit advances by 1. Commit with commit == alloc is a protocol error; the bench asserts on it.
- On flush_i, alloc <= commit (after any same-cycle commit applies). A same-cycle push is dropped, and push_ready_o is forced to 0 while flush_i is high. The drain FSM is unaffected.
- Drain FSM states and transitions:
  - IDLE: go to REQ when head != commit. Registered request fields are loaded from entry head on this transition.
  - REQ: dc_req_valid_o=1. Fields are held stable until dc_req_ready_i; on ready, go to WAIT.
  - WAIT: dc_req_valid_o=0. On dc_rsp_valid_i, head advances and the FSM returns to IDLE.
- An ack in the same cycle as acceptance is not possible; dc_rsp_valid_i outside WAIT is ignored and asserted as an error.
- Latency: commit_valid_i high in cycle t gives dc_req_valid_o high from cycle t+2 at the earliest. Ack in cycle a gives the freed entry, and push_ready_o if previously full, in cycle a+1.
- Byte enables from off=paddr[2:0]:
  - B: be=1<<off
  - H: be=3<<off
  - W: be=0xF<<off
  - D: be=0xFF
  - dc_req_data_o = data<<(8*off).
  - Upstream guarantees natural alignment; a misaligned push is a protocol error.
- Simultaneous push, commit, ack and flush in one cycle are all legal and are applied independently per the rules above.
- Pointer wrap from NR_SQ_ENTRIES-1 to 0 toggles the wrap bit. Full and empty are distinguished only by the wrap bit.
- Reset mid-transaction (REQ or WAIT) returns to IDLE and drops the in-flight request. dc_req_valid_o is 0 the cycle after rst. The dcache is reset in the same domain.
- sq_empty_o = (count == 0), registered-state derived.

Test Plan:
- Single store: push paddr=0x1003, size=B, data=0xAB, commit next cycle. Required: dc_req_valid_o 2 cycles after commit; paddr=0x1000, be=0x08, data=0xAB000000. Ack then sq_empty_o=1.
- Fill: 8 pushes with no commit. Required: push_ready_o=0 and sq_count_o=8. One commit plus dcache ack frees one entry; push_ready_o=1 the cycle after the ack.
- Flush: push 4 stores, commit 2, assert flush_i. Required: sq_count_o=2, exactly 2 dcache writes issued, then the next push receives sqid=2.
- Backpressure: hold dc_req_ready_i=0 for 5 cycles. Required: dc_req_valid_o and all dc_req_* fields stay stable; a late ack after 3 WAIT cycles advances head.
- Wrap: 20 push/commit/ack iterations through depth 8. Required: sqid sequence 0..7,0..7,0..3, in-order paddrs, never full/empty confusion.
- Simultaneous: push, commit and ack in one cycle with count=3. Required: count stays 3, commit pointer +1, and rst asserted mid-REQ gives dc_req_valid_o=0 next cycle.
